// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline constants: register file geometry and
// scoreboard age encoding used by ID, EX and the register file.
package hazard_scoreboard_pkg;

    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [1:0] age_t;

    localparam age_t AGE_EMPTY = 2'd0;
    localparam age_t AGE_EX    = 2'd1;
    localparam age_t AGE_MEM   = 2'd2;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/hazard_if.sv
// ID-stage hazard bundle: decoded operand info in,
// stall/bubble/issue decisions and scoreboard status out.
interface hazard_if #(
    parameter int CNT_W = 32
) ();
    import hazard_scoreboard_pkg::*;

    logic                id_valid;
    reg_idx_t            id_rs1;
    reg_idx_t            id_rs2;
    logic                id_use_rs1;
    logic                id_use_rs2;
    reg_idx_t            id_rd;
    logic                id_reg_write;
    logic                id_is_load;
    logic                id_wait_all;
    logic                flush;
    logic                pipe_freeze;
    logic                stall;
    logic                bubble;
    logic                issue;
    logic [NUM_REGS-1:0] busy_vec;
    logic [CNT_W-1:0]    stall_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output id_rd, id_reg_write, id_is_load, id_wait_all,
        output flush, pipe_freeze,
        input  stall, bubble, issue, busy_vec, stall_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  id_rd, id_reg_write, id_is_load, id_wait_all,
        input  flush, pipe_freeze,
        output stall, bubble, issue, busy_vec, stall_count
    );

endinterface

// File: rtl/hazard_scoreboard_entry.sv
// One scoreboard slot: tracks the youngest in-flight writer of a
// register as it moves EX -> MEM -> retired.
module hazard_scoreboard_entry
    import hazard_scoreboard_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic advance,
    input  logic set,
    input  logic set_load,
    output age_t age,
    output logic is_load
);

    age_t age_q, age_d;
    logic load_q, load_d;

    always_comb begin
        age_d  = age_q;
        load_d = load_q;
        if (advance) begin
            unique case (age_q)
                AGE_EX:  age_d = AGE_MEM;
                AGE_MEM: age_d = AGE_EMPTY;
                default: age_d = age_q;
            endcase
        end
        // A new issue replaces whatever older writer was aging here
        if (set) begin
            age_d  = AGE_EX;
            load_d = set_load;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            age_q  <= AGE_EMPTY;
            load_q <= 1'b0;
        end else begin
            age_q  <= age_d;
            load_q <= load_d;
        end
    end

    assign age     = age_q;
    assign is_load = load_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage load-use / drain stall generator; everything an ALU or
// MEM-stage load produces is left to the forwarding network.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic     clk,
    input  logic     reset,
    hazard_if.slave  bus
);

    logic [NUM_REGS-1:0][1:0] age;
    logic [NUM_REGS-1:0]      is_ld;
    logic [NUM_REGS-1:0]      busy;
    logic [NUM_REGS-1:0]      set;
    logic                     hz1;
    logic                     hz2;
    logic                     drain;
    logic                     stall;
    logic                     bubble;
    logic                     issue;
    logic                     advance;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    assign age[0]   = AGE_EMPTY;
    assign is_ld[0] = 1'b0;
    assign advance  = ~bus.pipe_freeze;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_ent
        hazard_scoreboard_entry u_ent (
            .clk      (clk),
            .reset    (reset),
            .advance  (advance),
            .set      (set[i]),
            .set_load (bus.id_is_load),
            .age      (age[i]),
            .is_load  (is_ld[i])
        );
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            busy[i] = (age[i] != AGE_EMPTY);
        end
    end

    // Only a load still in EX cannot be forwarded in time
    always_comb begin
        hz1 = bus.id_use_rs1 && (bus.id_rs1 != '0)
            && (age[bus.id_rs1] == AGE_EX) && is_ld[bus.id_rs1];
        hz2 = bus.id_use_rs2 && (bus.id_rs2 != '0)
            && (age[bus.id_rs2] == AGE_EX) && is_ld[bus.id_rs2];
        drain  = bus.id_wait_all && (|busy);
        stall  = reset && bus.id_valid && !bus.flush
            && (hz1 || hz2 || drain);
        bubble = reset && (stall || bus.flush) && !bus.pipe_freeze;
        issue  = reset && bus.id_valid && !stall
            && !bus.flush && !bus.pipe_freeze;
    end

    always_comb begin
        set = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            set[i] = issue && bus.id_reg_write
                && (bus.id_rd == REG_ADDR_W'(i));
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall && !bus.pipe_freeze && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.stall       = stall;
    assign bus.bubble      = bubble;
    assign bus.issue       = issue;
    assign bus.busy_vec    = busy;
    assign bus.stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: a list-of-writes reference model predicts each
// cycle's outputs; a negedge monitor pops and compares.
module tb_hazard_scoreboard;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    hazard_if #(.CNT_W(32)) hif ();

    hazard_scoreboard #(.CNT_W(32)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (hif.slave)
    );

    typedef struct {
        bit          st;
        bit          bub;
        bit          iss;
        logic [31:0] busy;
        logic [31:0] cnt;
    } exp_t;

    typedef struct {
        int rd;
        bit ld;
        int at;
    } wr_t;

    exp_t q[$];
    wr_t  inflight[$];
    int   adv;
    int   cnt_model;
    int   n_chk;
    int   n_fail;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("stall", 32'(hif.stall), 32'(e.st));
            chk("bubble", 32'(hif.bubble), 32'(e.bub));
            chk("issue", 32'(hif.issue), 32'(e.iss));
            chk("busy_vec", hif.busy_vec, e.busy);
            chk("stall_count", hif.stall_count, e.cnt);
        end
    end

    // Age of the youngest writer of r: 1 in EX, 2 in MEM, 0 none
    function automatic int age_of(input int r, output bit ld);
        ld = 1'b0;
        for (int k = inflight.size() - 1; k >= 0; k--) begin
            if (inflight[k].rd == r) begin
                int a;
                a = adv - inflight[k].at + 1;
                ld = inflight[k].ld;
                return (a <= 2) ? a : 0;
            end
        end
        return 0;
    endfunction

    task automatic model_reset();
        inflight.delete();
        adv = 0;
        cnt_model = 0;
    endtask

    task automatic cycle(input bit v, input int rs1, input int rs2,
                         input bit u1, input bit u2, input int rd,
                         input bit rw, input bit ld, input bit wa,
                         input bit fl, input bit fr);
        exp_t e;
        bit   l1, l2, lx, h1, h2, any;
        logic [31:0] bv;
        hif.id_valid     = v;
        hif.id_rs1       = 5'(rs1);
        hif.id_rs2       = 5'(rs2);
        hif.id_use_rs1   = u1;
        hif.id_use_rs2   = u2;
        hif.id_rd        = 5'(rd);
        hif.id_reg_write = rw;
        hif.id_is_load   = ld;
        hif.id_wait_all  = wa;
        hif.flush        = fl;
        hif.pipe_freeze  = fr;
        bv = '0;
        for (int r = 1; r < 32; r++) begin
            bv[r] = (age_of(r, lx) != 0);
        end
        any = (bv != 0);
        h1 = u1 && rs1 != 0 && age_of(rs1, l1) == 1 && l1;
        h2 = u2 && rs2 != 0 && age_of(rs2, l2) == 1 && l2;
        e.st   = v && !fl && (h1 || h2 || (wa && any));
        e.bub  = (e.st || fl) && !fr;
        e.iss  = v && !e.st && !fl && !fr;
        e.busy = bv;
        e.cnt  = 32'(cnt_model);
        q.push_back(e);
        @(posedge clk);
        if (!fr) begin
            if (e.st) cnt_model++;
            adv++;
            while (inflight.size() != 0 &&
                   adv - inflight[0].at + 1 > 2) begin
                void'(inflight.pop_front());
            end
            if (e.iss && rw && rd != 0) begin
                wr_t w;
                w.rd = rd;
                w.ld = ld;
                w.at = adv;
                inflight.push_back(w);
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        end
    endtask

    initial begin
        exp_t z;
        n_chk = 0;
        n_fail = 0;
        model_reset();
        hif.id_valid = 0; hif.id_rs1 = 0; hif.id_rs2 = 0;
        hif.id_use_rs1 = 0; hif.id_use_rs2 = 0; hif.id_rd = 0;
        hif.id_reg_write = 0; hif.id_is_load = 0;
        hif.id_wait_all = 0; hif.flush = 0; hif.pipe_freeze = 0;
        z.st = 0; z.bub = 0; z.iss = 0; z.busy = '0; z.cnt = '0;
        repeat (2) @(posedge clk);
        #1;
        q.push_back(z);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // load-use: one stall, then the consumer issues
        cycle(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);
        cycle(1, 5, 7, 1, 1, 6, 1, 0, 0, 0, 0);
        cycle(1, 5, 7, 1, 1, 6, 1, 0, 0, 0, 0);
        idle(3);
        // ALU producer forwards, busy for two cycles
        cycle(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
        cycle(1, 5, 0, 1, 0, 9, 0, 0, 0, 0, 0);
        idle(3);
        // load to x0 is never tracked
        cycle(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        cycle(1, 0, 0, 1, 1, 4, 1, 0, 0, 0, 0);
        idle(3);
        // freeze holds state and counter
        cycle(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) cycle(1, 5, 0, 1, 0, 6, 1, 0, 0, 0, 1);
        cycle(1, 5, 0, 1, 0, 6, 1, 0, 0, 0, 0);
        cycle(1, 5, 0, 1, 0, 6, 1, 0, 0, 0, 0);
        idle(3);
        // ecall drains outstanding writes
        cycle(1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) cycle(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(3);
        // flush with a load in EX: no stall, no new entry
        cycle(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);
        cycle(1, 5, 0, 1, 0, 7, 1, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // same-instruction rs==rd sees only the older load
        cycle(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0);
        cycle(1, 3, 0, 1, 0, 3, 1, 1, 0, 0, 0);
        cycle(1, 3, 0, 1, 0, 3, 1, 1, 0, 0, 0);
        cycle(1, 3, 0, 1, 0, 3, 1, 0, 0, 0, 0);
        idle(3);

        // reset asserted mid-stall clears everything at once
        cycle(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);
        cycle(1, 5, 0, 1, 0, 6, 1, 0, 0, 0, 0);
        rst_n = 1'b0;
        model_reset();
        #1;
        q.push_back(z);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1, 5, 0, 1, 0, 6, 1, 0, 0, 0, 0);
        idle(2);

        for (int n = 0; n < 600; n++) begin
            cycle($urandom_range(0, 7) != 0,
                  $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1), $urandom_range(0, 9) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
        end

        repeat (2) @(negedge clk);
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked",
                     q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
